// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus master: FSM states, access
// size codes, bus request payload and byte-strobe helpers.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // funct3[1:0] access size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // One bus beat as presented on the request channel
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } lsu_req_t;

    // Byte enables across two consecutive beats: low half is beat 0, high half beat 1
    function automatic logic [2*STRB_W-1:0] byte_strobe(input logic [1:0] size,
                                                        input logic [2:0] lane);
        logic [2*STRB_W-1:0] mask;
        case (size)
            SZ_B:    mask = 16'h0001;
            SZ_H:    mask = 16'h0003;
            SZ_W:    mask = 16'h000F;
            default: mask = 16'h00FF;
        endcase
        return mask << lane;
    endfunction

    // Access spills into the next 8-byte word when lane + size > 8
    function automatic logic crosses_beat(input logic [1:0] size,
                                          input logic [2:0] lane);
        return (4'(lane) + (4'd1 << size)) > 4'd8;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: joins two bus beats, extracts the bytes
// starting at the access lane and zero/sign-extends them to 64 bits.
// Ports: beat0_i/beat1_i  raw bus words (beat 1 only meaningful for split accesses)
//        lane_i           byte offset of the access inside beat 0
//        funct3_i         [1:0] size code, [2] unsigned load
//        result_c         extended load value
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] beat0_i,
    input  logic [XLEN-1:0] beat1_i,
    input  logic [2:0]      lane_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_c
);

    logic [XLEN-1:0] raw;

    // Byte gather then extension by size
    always_comb begin
        raw = XLEN'({beat1_i, beat0_i} >> {lane_i, 3'b000});
        case (funct3_i[1:0])
            SZ_B:    result_c = funct3_i[2] ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    result_c = funct3_i[2] ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    result_c = funct3_i[2] ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: result_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit bus master: turns one pipeline load/store into one or two
// 8-byte-aligned bus beats, waits for each response, and returns the
// extended load result with a one-cycle done pulse.
// Ports: clock/reset_n                 clock, async active-low reset
//        load_i/store_i/funct3_i/addr_i/sdata_i  pipeline request
//        stall_o (combinational), done_o, rdata_o  pipeline status/result
//        req_* / rsp_*                 single-outstanding bus request/response
module lsu_master
    import lsu_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter logic [63:0] MEM_BYTES = 64'd1 << 20
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   sdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [XLEN-1:0]   req_addr_o,
    output logic [XLEN-1:0]   req_wdata_o,
    output logic [STRB_W-1:0] req_wstrb_o,
    input  logic              rsp_valid_i,
    input  logic [XLEN-1:0]   rsp_rdata_i
);

    lsu_state_e state_q, state_d;

    lsu_req_t          req_q, req_d;
    logic [XLEN-1:0]   hi_addr_q, hi_addr_d;
    logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
    logic [STRB_W-1:0] hi_wstrb_q, hi_wstrb_d;
    logic              valid_q, valid_d;
    logic              pend_q, pend_d;
    logic              split_q, split_d;
    logic              done_q, done_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        lane_q, lane_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;

    logic [XLEN-1:0]     off_c;
    logic [XLEN-1:0]     base_c;
    logic [2:0]          lane_c;
    logic [2*STRB_W-1:0] strb_c;
    logic [2*XLEN-1:0]   wide_c;
    logic                cross_c;
    logic                capture_c;
    logic [XLEN-1:0]     align_b0_c;
    logic [XLEN-1:0]     align_c;

    // Offset, lane and two-beat strobe/data images of the incoming request
    assign off_c     = (addr_i - ADDR_BASE) % MEM_BYTES;
    assign lane_c    = off_c[2:0];
    assign base_c    = {off_c[XLEN-1:3], 3'b000};
    assign strb_c    = byte_strobe(funct3_i[1:0], lane_c);
    assign wide_c    = {{XLEN{1'b0}}, sdata_i} << {lane_c, 3'b000};
    assign cross_c   = crosses_beat(funct3_i[1:0], lane_c);
    assign capture_c = (state_q == ST_IDLE) && (load_i || store_i);

    // For split loads beat 0 was parked on the first response
    assign align_b0_c = split_q ? beat0_q : rsp_rdata_i;

    lsu_load_align u_align (
        .beat0_i  (align_b0_c),
        .beat1_i  (rsp_rdata_i),
        .lane_i   (lane_q),
        .funct3_i (funct3_q),
        .result_c (align_c)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_i || store_i) state_d = ST_REQ;
            ST_REQ:  if (req_ready_i)       state_d = ST_WAIT;
            ST_WAIT: if (rsp_valid_i)       state_d = pend_q ? ST_REQ : ST_DONE;
            ST_DONE:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        req_d      = req_q;
        hi_addr_d  = hi_addr_q;
        hi_wdata_d = hi_wdata_q;
        hi_wstrb_d = hi_wstrb_q;
        pend_d     = pend_q;
        split_d    = split_q;
        funct3_d   = funct3_q;
        lane_d     = lane_q;
        beat0_d    = beat0_q;
        rdata_d    = rdata_q;
        valid_d    = (state_d == ST_REQ);
        done_d     = (state_d == ST_DONE);

        if (capture_c) begin
            req_d.we    = store_i;
            req_d.addr  = base_c;
            req_d.wdata = wide_c[XLEN-1:0];
            req_d.wstrb = strb_c[STRB_W-1:0];
            hi_addr_d   = (base_c + 64'd8) % MEM_BYTES;
            hi_wdata_d  = wide_c[2*XLEN-1:XLEN];
            hi_wstrb_d  = strb_c[2*STRB_W-1:STRB_W];
            pend_d      = cross_c;
            split_d     = cross_c;
            funct3_d    = funct3_i;
            lane_d      = lane_c;
        end

        if (state_q == ST_WAIT && rsp_valid_i) begin
            if (pend_q) begin
                // Present the spill beat; keep beat 0 data for the gather
                req_d.addr  = hi_addr_q;
                req_d.wdata = hi_wdata_q;
                req_d.wstrb = hi_wstrb_q;
                pend_d      = 1'b0;
                beat0_d     = rsp_rdata_i;
            end else if (!req_q.we) begin
                rdata_d = align_c;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= '0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_wstrb_q <= '0;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            split_q    <= 1'b0;
            done_q     <= 1'b0;
            funct3_q   <= '0;
            lane_q     <= '0;
            beat0_q    <= '0;
            rdata_q    <= '0;
        end else begin
            req_q      <= req_d;
            hi_addr_q  <= hi_addr_d;
            hi_wdata_q <= hi_wdata_d;
            hi_wstrb_q <= hi_wstrb_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            split_q    <= split_d;
            done_q     <= done_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            beat0_q    <= beat0_d;
            rdata_q    <= rdata_d;
        end
    end

    // Stall is combinational so a new request holds the pipeline in the same cycle
    assign stall_o     = (state_q == ST_IDLE) ? (load_i || store_i)
                                              : (state_q == ST_REQ || state_q == ST_WAIT);
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign req_valid_o = valid_q;
    assign req_we_o    = req_q.we;
    assign req_addr_o  = req_q.addr;
    assign req_wdata_o = req_q.wdata;
    assign req_wstrb_o = req_q.wstrb;

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: directed scenarios plus randomized
// loads/stores against a byte-level reference memory.
module tb_lsu_master;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] MEM  = 64'd1 << 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_i, store_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, sdata_i;
    logic        stall_o, done_o;
    logic [63:0] rdata_o;
    logic        req_valid_o, req_ready_i, req_we_o;
    logic [63:0] req_addr_o, req_wdata_o;
    logic [7:0]  req_wstrb_o;
    logic        rsp_valid_i;
    logic [63:0] rsp_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ref_mem [logic [63:0]];
    logic [7:0]  bus_mem [logic [63:0]];
    logic [63:0] exp_rdata;

    logic [63:0] seen_addr  [2];
    logic [63:0] seen_wdata [2];
    logic [7:0]  seen_strb  [2];
    int          seen_cyc;

    always #5 clock = ~clock;

    lsu_master #(.ADDR_BASE(BASE), .MEM_BYTES(MEM)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (load_i),
        .store_i     (store_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .sdata_i     (sdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .req_we_o    (req_we_o),
        .req_addr_o  (req_addr_o),
        .req_wdata_o (req_wdata_o),
        .req_wstrb_o (req_wstrb_o),
        .rsp_valid_i (rsp_valid_i),
        .rsp_rdata_i (rsp_rdata_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [63:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [63:0] strb2mask(input logic [7:0] s);
        logic [63:0] m;
        for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{s[j]}};
        return m;
    endfunction

    task automatic poke(input logic [63:0] off, input logic [7:0] b);
        ref_mem[off] = b;
        bus_mem[off] = b;
    endtask

    // Garbage on pipeline inputs while the block is busy
    task automatic scramble();
        load_i   = 1'($urandom);
        store_i  = 1'($urandom);
        funct3_i = 3'($urandom);
        addr_i   = {$urandom, $urandom};
        sdata_i  = {$urandom, $urandom};
    endtask

    // One full access; called at a falling edge with the DUT idle
    task automatic access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] sd, input int rdy_dly, input int rsp_dly);
        logic [63:0] off, a, aa, val, rsp;
        logic [63:0] snap_addr, snap_wdata;
        logic [7:0]  snap_strb;
        logic        snap_we;
        logic [63:0] e_addr [2];
        logic [7:0]  e_strb [2];
        logic [63:0] e_wd   [2];
        int size, nb, cyc;

        off  = (addr - BASE) % MEM;
        size = 1 << f3[1:0];
        nb   = 0;
        val  = '0;
        for (int i = 0; i < size; i++) begin
            a  = (off + 64'(i)) % MEM;
            aa = a & ~64'd7;
            if (nb == 0 || aa != e_addr[nb-1]) begin
                e_addr[nb] = aa;
                e_strb[nb] = '0;
                e_wd[nb]   = '0;
                nb++;
            end
            e_strb[nb-1][a[2:0]]          = 1'b1;
            e_wd[nb-1][8*a[2:0] +: 8]     = sd[8*i +: 8];
            if (we) ref_mem[a] = sd[8*i +: 8];
            else    val[8*i +: 8] = ref_rd(a);
        end
        if (!we) begin
            if (!f3[2] && size < 8 && val[8*size-1]) val = val | (~64'd0 << (8*size));
            exp_rdata = val;
        end

        load_i   = !we;
        store_i  = we;
        funct3_i = f3;
        addr_i   = addr;
        sdata_i  = sd;
        #1;
        check("stall_on_issue", stall_o, 1);
        check("done_idle", done_o, 0);
        @(negedge clock);
        cyc = 1;
        for (int b = 0; b < nb; b++) begin
            scramble();
            check("req_valid", req_valid_o, 1);
            check("req_we", req_we_o, we);
            check("req_addr", req_addr_o, e_addr[b]);
            if (we) begin
                check("req_wstrb", req_wstrb_o, e_strb[b]);
                check("req_wdata", req_wdata_o & strb2mask(e_strb[b]), e_wd[b]);
            end
            check("stall_req", stall_o, 1);
            snap_addr  = req_addr_o;
            snap_wdata = req_wdata_o;
            snap_strb  = req_wstrb_o;
            snap_we    = req_we_o;
            seen_addr[b]  = snap_addr;
            seen_wdata[b] = snap_wdata;
            seen_strb[b]  = snap_strb;
            for (int k = 0; k < rdy_dly; k++) begin
                req_ready_i = 1'b0;
                rsp_valid_i = 1'($urandom);
                rsp_rdata_i = {$urandom, $urandom};
                @(negedge clock);
                cyc++;
                scramble();
                check("hold_valid", req_valid_o, 1);
                check("hold_addr", req_addr_o, snap_addr);
                check("hold_wdata", req_wdata_o, snap_wdata);
                check("hold_wstrb", req_wstrb_o, snap_strb);
                check("hold_we", req_we_o, snap_we);
                check("hold_stall", stall_o, 1);
            end
            rsp_valid_i = 1'b0;
            req_ready_i = 1'b1;
            @(negedge clock);
            cyc++;
            req_ready_i = 1'b0;
            for (int k = 0; k < rsp_dly; k++) begin
                check("wait_no_req", req_valid_o, 0);
                check("wait_stall", stall_o, 1);
                check("wait_no_done", done_o, 0);
                @(negedge clock);
                cyc++;
                scramble();
            end
            check("wait_no_req", req_valid_o, 0);
            check("wait_stall", stall_o, 1);
            rsp = '0;
            for (int j = 0; j < 8; j++) begin
                rsp[8*j +: 8] = bus_rd(snap_addr + 64'(j));
                if (snap_we && snap_strb[j]) bus_mem[snap_addr + 64'(j)] = snap_wdata[8*j +: 8];
            end
            rsp_rdata_i = rsp;
            rsp_valid_i = 1'b1;
            @(negedge clock);
            cyc++;
            rsp_valid_i = 1'b0;
            rsp_rdata_i = {$urandom, $urandom};
        end
        check("done_pulse", done_o, 1);
        check("done_stall", stall_o, 0);
        check("done_no_req", req_valid_o, 0);
        check("rdata", rdata_o, exp_rdata);
        seen_cyc = cyc;
        scramble();
        @(negedge clock);
        load_i  = 1'b0;
        store_i = 1'b0;
        #1;
        check("done_one_cycle", done_o, 0);
        check("idle_stall", stall_o, 0);
        check("rdata_hold", rdata_o, exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r_off, r_addr, v;
        int          k;

        reset_n     = 1'b0;
        load_i      = 1'b0;
        store_i     = 1'b0;
        funct3_i    = '0;
        addr_i      = '0;
        sdata_i     = '0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_rdata_i = '0;
        exp_rdata   = '0;

        repeat (2) @(negedge clock);
        check("rst_valid", req_valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_addr", req_addr_o, 0);
        check("rst_wstrb", req_wstrb_o, 0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 64; i++) poke(64'(i), 8'($urandom));
        for (int i = 0; i < 16; i++) poke(MEM - 64'd16 + 64'(i), 8'($urandom));

        // LW at base+4 returning DEADBEEF in the upper word
        for (int i = 0; i < 4; i++) poke(64'(i), 8'h00);
        poke(64'd4, 8'hEF); poke(64'd5, 8'hBE); poke(64'd6, 8'hAD); poke(64'd7, 8'hDE);
        access(1'b0, 3'b010, BASE + 64'd4, 64'd0, 0, 0);
        check("lw_value", rdata_o, 64'hFFFF_FFFF_DEAD_BEEF);
        check("lw_latency", 64'(seen_cyc), 64'd3);

        // LBU / LB of 0x80
        poke(64'd3, 8'h80);
        access(1'b0, 3'b100, BASE + 64'd3, 64'd0, 0, 1);
        check("lbu_value", rdata_o, 64'h80);
        access(1'b0, 3'b000, BASE + 64'd3, 64'd0, 1, 0);
        check("lb_value", rdata_o, 64'hFFFF_FFFF_FFFF_FF80);

        // SH spanning two beats
        access(1'b1, 3'b001, BASE + 64'd7, 64'hABCD_0000_0000_1234, 0, 0);
        check("sh_b0_addr", seen_addr[0], 64'h0);
        check("sh_b0_strb", 64'(seen_strb[0]), 64'h80);
        check("sh_b0_byte", 64'(seen_wdata[0][63:56]), 64'h34);
        check("sh_b1_addr", seen_addr[1], 64'h8);
        check("sh_b1_strb", 64'(seen_strb[1]), 64'h01);
        check("sh_b1_byte", 64'(seen_wdata[1][7:0]), 64'h12);

        // Ready held low for 5 cycles on a split LD
        access(1'b0, 3'b011, BASE + 64'h2D, 64'd0, 5, 0);

        // SD then LD to the same address, back to back
        v = {$urandom, $urandom};
        access(1'b1, 3'b011, BASE + 64'h20, v, 0, 1);
        access(1'b0, 3'b011, BASE + 64'h20, 64'd0, 0, 0);
        check("sd_ld_value", rdata_o, v);

        // Reset while waiting for a response; late response must be ignored
        store_i  = 1'b1;
        funct3_i = 3'b011;
        addr_i   = BASE + 64'h18;
        sdata_i  = 64'hCAFE_F00D_1234_5678;
        @(negedge clock);
        store_i     = 1'b0;
        req_ready_i = 1'b1;
        check("rw_req_valid", req_valid_o, 1);
        @(negedge clock);
        req_ready_i = 1'b0;
        check("rw_in_wait", req_valid_o, 0);
        check("rw_stall", stall_o, 1);
        reset_n = 1'b0;
        #1;
        check("rw_done", done_o, 0);
        check("rw_valid", req_valid_o, 0);
        check("rw_we", req_we_o, 0);
        check("rw_addr", req_addr_o, 0);
        check("rw_wdata", req_wdata_o, 0);
        check("rw_wstrb", req_wstrb_o, 0);
        check("rw_rdata", rdata_o, 0);
        check("rw_idle_stall", stall_o, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        rsp_valid_i = 1'b1;
        rsp_rdata_i = {$urandom, $urandom};
        #1;
        check("rw_late_rsp_stall", stall_o, 0);
        @(negedge clock);
        rsp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rw_no_done", done_o, 0);
            check("rw_no_req", req_valid_o, 0);
            check("rw_rdata_zero", rdata_o, 0);
            @(negedge clock);
        end
        exp_rdata = '0;

        // Randomized loads/stores, including wrap at the top of memory and aliased bases
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) r_off = MEM - 64'd16 + 64'($urandom_range(0, 15));
            else                           r_off = 64'($urandom_range(0, 55));
            k      = $urandom_range(0, 3);
            r_addr = BASE + r_off + (64'(k) - 64'd1) * MEM;
            access(1'($urandom), 3'($urandom), r_addr, {$urandom, $urandom},
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h8000_0000, the physical base subtracted from every pipeline address.
REQ-002 SHALL have parameter MEM_BYTES, default 1<<20, the memory size; bus offsets SHALL be taken modulo MEM_BYTES.
REQ-003 SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port load_i  in  1  the pipeline requests a load.
REQ-006 SHALL have port store_i  in  1  the pipeline requests a store.
REQ-007 SHALL have port funct3_i  in  3  [1:0] size code (0=B,1=H,2=W,3=D); [2] is unsigned-load.
REQ-008 SHALL have port addr_i  in  64  byte address of the access.
REQ-009 SHALL have port sdata_i  in  64  store data, right-aligned.
REQ-010 SHALL have port stall_o  out  1  hold the pipeline.
REQ-011 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata_o  out  64  extended load result.
REQ-013 SHALL have bus ports req_valid_o out 1, req_ready_i in 1, req_we_o out 1, req_addr_o out 64 (8-byte aligned offset), req_wdata_o out 64, req_wstrb_o out 8, rsp_valid_i in 1, rsp_rdata_i in 64.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, DONE; one outstanding bus transaction at a time.
REQ-015 In IDLE, with load_i or store_i set, SHALL capture addr, funct3, sdata and the operation, and go to REQ; store_i SHALL win if both are set.
REQ-016 stall_o SHALL be high combinationally in IDLE when load_i|store_i, and in REQ and WAIT; it SHALL be low in DONE and in an idle IDLE.
REQ-017 The computed offset SHALL be off = (addr-ADDR_BASE) mod MEM_BYTES, with lane = off[2:0] and size = 1<<funct3[1:0].
REQ-018 Beat 0 SHALL use req_addr_o = off & ~7; if lane+size>8, a second beat SHALL follow at beat-0 address + 8 (wrapping modulo MEM_BYTES).
REQ-019 The wstrb field SHALL equal (((1<<size)-1)<<lane) bits [7:0] for beat 0 and bits [15:8] for beat 1; wdata SHALL be sdata shifted left by 8*lane bits, low and high 64-bit halves respectively.
REQ-020 req_valid_o SHALL be high only in REQ, with the payload stable until req_ready_i; on the handshake the block SHALL go to WAIT.
REQ-021 rsp_valid_i SHALL be honoured only in WAIT, at the earliest the cycle after the handshake, for loads and stores alike; rsp_valid_i outside WAIT SHALL be ignored.
REQ-022 On a response in WAIT, the block SHALL go to REQ for a pending beat 1, or to DONE otherwise.
REQ-023 Load bytes SHALL be gathered from beats 0 and 1 in lane order and then zero-extended (funct3[2]=1) or sign-extended from size*8 bits; funct3=3'b111 SHALL be treated as LD.
REQ-024 In DONE, done_o SHALL be 1 for one cycle, and rdata_o SHALL be updated for loads only, then held until the next load completes; the next state SHALL be IDLE.
REQ-025 Inputs SHALL be ignored in REQ, WAIT and DONE.

Reset
REQ-026 On reset_n low the block SHALL go to IDLE immediately, and req_valid_o, req_we_o, done_o, rdata_o, req_addr_o, req_wdata_o and req_wstrb_o SHALL be 0; an in-flight transaction SHALL be abandoned and its response ignored.

Structure
REQ-027 State encoding, size codes and a byte-strobe helper function SHALL live in shared package lsu_pkg.
REQ-028 Load alignment and extension SHALL be a combinational sub-module lsu_load_align (inputs: two beats, lane, funct3; output: 64-bit result).

Verification
REQ-029 LW at 0x8000_0004, bus ready always and response next cycle with beat 0xDEADBEEF_00000000 -> wstrb unused, rdata_o=0xFFFF_FFFF_DEAD_BEEF, done_o 3 cycles after issue.
REQ-030 SH 0x1234 at 0x8000_0007 -> two beats: addr 0x0 with wstrb 0x80 and wdata[63:56]=0x34, then addr 0x8 with wstrb 0x01 and wdata[7:0]=0x12.
REQ-031 LBU at 0x8000_0003 with beat byte 0x80 -> rdata_o=0x80; LB same -> rdata_o=0xFFFF_FFFF_FFFF_FF80.
REQ-032 req_ready_i low for 5 cycles -> req_valid_o and payload stable all 5 cycles, stall_o high throughout.
REQ-033 reset_n low in WAIT, with rsp_valid_i asserted 1 cycle after release -> state IDLE, done_o never pulses, rdata_o=0.
REQ-034 Back-to-back SD then LD to the same address -> LD returns the stored value; no cycle has req_valid_o high while a response is outstanding.
